// File: rtl/psum_ln_pkg.sv
// Shared defaults and index / link-enable helpers for the psum local-network router.
package psum_ln_pkg;

    localparam int DATA_BITS_DEF  = 32;
    localparam int GROUP_ROWS_DEF = 3;

    function automatic int pe_idx(input int r, input int c, input int num_cols);
        return r * num_cols + c;
    endfunction

    // Last row of a depthwise group: its link is cut and it is fed a constant zero psum.
    function automatic logic dw_zero_row(input logic depthwise, input int r, input int group_rows);
        return depthwise && (((r + 1) % group_rows) == 0);
    endfunction

    function automatic logic link_en(input logic ln_bit, input logic depthwise, input int r,
                                     input int group_rows);
        return ln_bit && !dw_zero_row(depthwise, r, group_rows);
    endfunction

endpackage

// File: rtl/ln_skid_fifo.sv
// Two-entry link buffer between a PE opsum and the PE ipsum of the row below it.
module ln_skid_fifo
    import psum_ln_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [DATA_BITS-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 push;
    logic                 pop;

    // A full buffer still admits a word in the cycle its head is being popped.
    always_comb begin
        out_valid = (count != 2'd0);
        out_data  = mem[rd_ptr];
        in_ready  = (count != 2'd2) || out_ready;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/psum_ln_router.sv
// Routes PE psums between adjacent rows through link buffers, or to GIN/GON when unlinked.
// Optional link-pop counter output ln_fwd_cnt is built when LN_PERF_CNT_EN is defined.
module psum_ln_router
    import psum_ln_pkg::*;
#(
    parameter int NUM_ROWS   = 6,
    parameter int NUM_COLS   = 8,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int GROUP_ROWS = GROUP_ROWS_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  set_LN,
    input  logic [NUM_ROWS-2:0]                   LN_config_in,
    input  logic                                  set_mode,
    input  logic                                  depthwise_in,
    input  logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] pe_opsum,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           pe_opsum_valid,
    output logic [NUM_ROWS*NUM_COLS-1:0]           pe_opsum_ready,
    output logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] pe_ipsum,
    output logic [NUM_ROWS*NUM_COLS-1:0]           pe_ipsum_valid,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           pe_ipsum_ready,
    input  logic [DATA_BITS-1:0]                  gin_ipsum,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           gin_ipsum_valid,
    output logic [NUM_ROWS*NUM_COLS-1:0]           gin_ipsum_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]           gon_valid,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           gon_ready,
    output logic                                  busy,
    output logic                                  cfg_err
`ifdef LN_PERF_CNT_EN
    ,
    output logic [31:0]                           ln_fwd_cnt
`endif
);

    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int NL = (NUM_ROWS - 1) * NUM_COLS;

    // Handshake: a word moves on any edge where valid && ready; valid never waits on ready,
    // and a link's opsum ready may follow its downstream ipsum ready in the same cycle.

    logic [NUM_ROWS-2:0]  ln_config;
    logic                 depthwise;
    logic [NUM_ROWS-1:0]  row_link;   // row r ipsum comes from the link buffer
    logic [NUM_ROWS-1:0]  src_link;   // row r opsum goes into the link buffer
    logic [DATA_BITS-1:0] fifo_ipsum_data [N];
    logic [N-1:0]         fifo_ipsum_valid;
    logic [N-1:0]         fifo_opsum_ready;
    logic                 unused_row0_opsum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ln_config <= '0;
            depthwise <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= (set_LN || set_mode) && busy;
            if (!busy) begin
                if (set_LN)   ln_config <= LN_config_in;
                if (set_mode) depthwise <= depthwise_in;
            end
        end
    end

    always_comb begin
        row_link = '0;
        for (int r = 0; r < NUM_ROWS - 1; r++) begin
            row_link[r] = link_en(ln_config[r], depthwise, r, GROUP_ROWS);
        end
        src_link = {row_link[NUM_ROWS-2:0], 1'b0};
    end

    for (genvar l = 0; l < NL; l++) begin : g_link
        ln_skid_fifo #(.DATA_BITS(DATA_BITS)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .in_data  (pe_opsum[(l+NUM_COLS)*DATA_BITS +: DATA_BITS]),
            .in_valid (row_link[l/NUM_COLS] && pe_opsum_valid[l+NUM_COLS]),
            .in_ready (fifo_opsum_ready[l+NUM_COLS]),
            .out_data (fifo_ipsum_data[l]),
            .out_valid(fifo_ipsum_valid[l]),
            .out_ready(row_link[l/NUM_COLS] && pe_ipsum_ready[l])
        );
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_edge
        assign fifo_ipsum_data[NL+c]  = '0;
        assign fifo_ipsum_valid[NL+c] = 1'b0;
        assign fifo_opsum_ready[c]    = 1'b0;
    end

    // GON samples pe_opsum itself, so the row-0 data never passes through here.
    assign unused_row0_opsum = ^pe_opsum[NUM_COLS*DATA_BITS-1:0];
    assign busy              = |fifo_ipsum_valid;

    always_comb begin
        pe_ipsum        = '0;
        pe_ipsum_valid  = '0;
        gin_ipsum_ready = '0;
        gon_valid       = '0;
        pe_opsum_ready  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                int i;
                i = pe_idx(r, c, NUM_COLS);
                if (dw_zero_row(depthwise, r, GROUP_ROWS)) begin
                    pe_ipsum_valid[i] = 1'b1;
                end else if (row_link[r]) begin
                    pe_ipsum[i*DATA_BITS +: DATA_BITS] = fifo_ipsum_data[i];
                    pe_ipsum_valid[i]                  = fifo_ipsum_valid[i];
                end else begin
                    pe_ipsum[i*DATA_BITS +: DATA_BITS] = gin_ipsum;
                    pe_ipsum_valid[i]                  = gin_ipsum_valid[i];
                    gin_ipsum_ready[i]                 = pe_ipsum_ready[i];
                end
                if (src_link[r]) begin
                    pe_opsum_ready[i] = fifo_opsum_ready[i];
                end else begin
                    gon_valid[i]      = pe_opsum_valid[i];
                    pe_opsum_ready[i] = gon_ready[i];
                end
            end
        end
    end

`ifdef LN_PERF_CNT_EN
    localparam int PW = $clog2(NL + 1);

    logic [PW-1:0] pop_cnt;
    logic [32:0]   cnt_sum;

    always_comb begin
        pop_cnt = '0;
        for (int l = 0; l < NL; l++) begin
            pop_cnt = pop_cnt + PW'(fifo_ipsum_valid[l] && row_link[l/NUM_COLS] && pe_ipsum_ready[l]);
        end
        cnt_sum = {1'b0, ln_fwd_cnt} + 33'(pop_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ln_fwd_cnt <= '0;
        end else if (set_LN && !busy) begin
            ln_fwd_cnt <= '0;
        end else begin
            ln_fwd_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_psum_ln_router.sv
// Directed + randomized bench for psum_ln_router against a per-link queue reference model.
module tb_psum_ln_router;

    localparam int NR = 6;
    localparam int NC = 8;
    localparam int DW = 32;
    localparam int G  = 3;
    localparam int N  = NR * NC;
    localparam int NL = (NR - 1) * NC;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            set_LN;
    logic [NR-2:0]   LN_config_in;
    logic            set_mode;
    logic            depthwise_in;
    logic [N*DW-1:0] pe_opsum;
    logic [N-1:0]    pe_opsum_valid;
    logic [N-1:0]    pe_opsum_ready;
    logic [N*DW-1:0] pe_ipsum;
    logic [N-1:0]    pe_ipsum_valid;
    logic [N-1:0]    pe_ipsum_ready;
    logic [DW-1:0]   gin_ipsum;
    logic [N-1:0]    gin_ipsum_valid;
    logic [N-1:0]    gin_ipsum_ready;
    logic [N-1:0]    gon_valid;
    logic [N-1:0]    gon_ready;
    logic            busy;
    logic            cfg_err;
`ifdef LN_PERF_CNT_EN
    logic [31:0]     ln_fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: configuration plus an ordered word list per link (index = dest PE)
    logic [NR-2:0] m_ln;
    logic          m_dw;
    logic          m_cfg_err;
    logic [31:0]   m_perf;
    int            m_cnt [NL];
    logic [DW-1:0] m_w   [NL][2];

    psum_ln_router #(.NUM_ROWS(NR), .NUM_COLS(NC), .DATA_BITS(DW), .GROUP_ROWS(G)) dut (
        .clk            (clk),
        .rst            (rst),
        .set_LN         (set_LN),
        .LN_config_in   (LN_config_in),
        .set_mode       (set_mode),
        .depthwise_in   (depthwise_in),
        .pe_opsum       (pe_opsum),
        .pe_opsum_valid (pe_opsum_valid),
        .pe_opsum_ready (pe_opsum_ready),
        .pe_ipsum       (pe_ipsum),
        .pe_ipsum_valid (pe_ipsum_valid),
        .pe_ipsum_ready (pe_ipsum_ready),
        .gin_ipsum      (gin_ipsum),
        .gin_ipsum_valid(gin_ipsum_valid),
        .gin_ipsum_ready(gin_ipsum_ready),
        .gon_valid      (gon_valid),
        .gon_ready      (gon_ready),
        .busy           (busy),
        .cfg_err        (cfg_err)
`ifdef LN_PERF_CNT_EN
        ,
        .ln_fwd_cnt     (ln_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic zero_row(input int r);
        return m_dw && (((r + 1) % G) == 0);
    endfunction

    // true when row d receives its ipsum from row d+1 through a link buffer
    function automatic logic link_into(input int d);
        if (d < 0 || d > NR - 2) return 1'b0;
        return m_ln[d] && !zero_row(d);
    endfunction

    function automatic logic [N-1:0] rnd_n();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[N-1:0];
    endfunction

    task automatic reset_model();
        m_ln      = '0;
        m_dw      = 1'b0;
        m_cfg_err = 1'b0;
        m_perf    = '0;
        for (int l = 0; l < NL; l++) m_cnt[l] = 0;
    endtask

    task automatic check_all();
        logic [N-1:0] e_iv, e_gr, e_gv, e_or;
        logic         e_busy;
        #2;
        e_iv = '0; e_gr = '0; e_gv = '0; e_or = '0; e_busy = 1'b0;
        for (int l = 0; l < NL; l++) if (m_cnt[l] > 0) e_busy = 1'b1;
        for (int i = 0; i < N; i++) begin
            int r;
            r = i / NC;
            if (zero_row(r)) begin
                e_iv[i] = 1'b1;
                chk("ipsum_zero", i, 64'(pe_ipsum[i*DW +: DW]), 64'(0));
            end else if (link_into(r)) begin
                e_iv[i] = (m_cnt[i] > 0);
                if (m_cnt[i] > 0) chk("ipsum_link", i, 64'(pe_ipsum[i*DW +: DW]), 64'(m_w[i][0]));
            end else begin
                e_iv[i] = gin_ipsum_valid[i];
                e_gr[i] = pe_ipsum_ready[i];
                chk("ipsum_gin", i, 64'(pe_ipsum[i*DW +: DW]), 64'(gin_ipsum));
            end
            if (link_into(r - 1)) begin
                e_or[i] = (m_cnt[i-NC] < 2) || pe_ipsum_ready[i-NC];
            end else begin
                e_gv[i] = pe_opsum_valid[i];
                e_or[i] = gon_ready[i];
            end
        end
        chk("ipsum_valid", 0, 64'(pe_ipsum_valid), 64'(e_iv));
        chk("gin_ready", 0, 64'(gin_ipsum_ready), 64'(e_gr));
        chk("gon_valid", 0, 64'(gon_valid), 64'(e_gv));
        chk("opsum_ready", 0, 64'(pe_opsum_ready), 64'(e_or));
        chk("busy", 0, 64'(busy), 64'(e_busy));
        chk("cfg_err", 0, 64'(cfg_err), 64'(m_cfg_err));
`ifdef LN_PERF_CNT_EN
        chk("ln_fwd_cnt", 0, 64'(ln_fwd_cnt), 64'(m_perf));
`endif
    endtask

    // advance the model by one clock using the inputs currently applied, then cross the edge
    task automatic tick();
        int          pops;
        logic        busy_m, pop, push;
        logic [32:0] sum;
        pops = 0;
        busy_m = 1'b0;
        for (int l = 0; l < NL; l++) if (m_cnt[l] > 0) busy_m = 1'b1;
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                if (link_into(l / NC)) begin
                    pop  = (m_cnt[l] > 0) && pe_ipsum_ready[l];
                    push = pe_opsum_valid[l+NC] && ((m_cnt[l] < 2) || pe_ipsum_ready[l]);
                    if (pop) begin
                        m_w[l][0] = m_w[l][1];
                        m_cnt[l]--;
                        pops++;
                    end
                    if (push) begin
                        m_w[l][m_cnt[l]] = pe_opsum[(l+NC)*DW +: DW];
                        m_cnt[l]++;
                    end
                end
            end
            m_cfg_err = (set_LN || set_mode) && busy_m;
            sum = {1'b0, m_perf} + 33'(pops);
            m_perf = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            if (!busy_m) begin
                if (set_LN) begin
                    m_ln   = LN_config_in;
                    m_perf = '0;
                end
                if (set_mode) m_dw = depthwise_in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        check_all();
        tick();
    endtask

    task automatic quiet();
        set_LN = 1'b0; LN_config_in = '0; set_mode = 1'b0; depthwise_in = 1'b0;
        pe_opsum = '0; pe_opsum_valid = '0; pe_ipsum_ready = '0;
        gin_ipsum = '0; gin_ipsum_valid = '0; gon_ready = '0;
    endtask

    task automatic drain();
        set_LN = 1'b0; set_mode = 1'b0;
        pe_opsum_valid = '0; pe_ipsum_ready = '1;
        repeat (3) step();
    endtask

    task automatic load_ln(input logic [NR-2:0] cfg);
        set_LN = 1'b1; LN_config_in = cfg;
        step();
        set_LN = 1'b0;
    endtask

    task automatic rand_traffic(input int cycles, input int cfg_pct);
        for (int k = 0; k < cycles; k++) begin
            for (int i = 0; i < N; i++) pe_opsum[i*DW +: DW] = $urandom;
            pe_opsum_valid  = rnd_n();
            pe_ipsum_ready  = rnd_n();
            gin_ipsum       = $urandom;
            gin_ipsum_valid = rnd_n();
            gon_ready       = rnd_n();
            set_LN          = ($urandom_range(0, 99) < cfg_pct);
            LN_config_in    = NR'($urandom) ;
            set_mode        = ($urandom_range(0, 99) < cfg_pct);
            depthwise_in    = 1'($urandom_range(0, 1));
            step();
        end
        set_LN = 1'b0; set_mode = 1'b0;
    endtask

    initial begin
        quiet();
        reset_model();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // unlinked: every row on GIN/GON
        rand_traffic(12, 0);
        quiet();

        // two words queued behind a stalled consumer, third refused, then ordered release
        load_ln(5'b00001);
        step();
        pe_opsum_valid[8] = 1'b1; pe_opsum[8*DW +: DW] = 32'h11;
        step();
        pe_opsum[8*DW +: DW] = 32'h22;
        step();
        pe_opsum[8*DW +: DW] = 32'h33;
        check_all();
        chk("third_push_ready", 8, 64'(pe_opsum_ready[8]), 64'(0));
        tick();
        pe_opsum_valid[8] = 1'b0; pe_ipsum_ready[0] = 1'b1;
        check_all();
        chk("release_first", 0, 64'(pe_ipsum[DW-1:0]), 64'h11);
        tick();
        check_all();
        chk("release_second", 0, 64'(pe_ipsum[DW-1:0]), 64'h22);
        tick();
        step();

        // configuration attempt while a word is buffered
        pe_opsum_valid[8] = 1'b1; pe_opsum[8*DW +: DW] = 32'h44; pe_ipsum_ready[0] = 1'b0;
        step();
        pe_opsum_valid[8] = 1'b0;
        load_ln(5'b11111);
        check_all();
        chk("cfg_err_pulse", 0, 64'(cfg_err), 64'(1));
        tick();
        pe_opsum_valid[16] = 1'b1;
        check_all();
        chk("cfg_err_clear", 0, 64'(cfg_err), 64'(0));
        chk("cfg_kept_gon", 16, 64'(gon_valid[16]), 64'(1));
        tick();
        drain();

        // one-cycle link latency and busy until popped
        quiet();
        load_ln(5'b11111);
        step();
        pe_opsum_valid[11] = 1'b1; pe_opsum[11*DW +: DW] = 32'hA5;
        step();
        pe_opsum_valid[11] = 1'b0;
        check_all();
        chk("lat_valid", 3, 64'(pe_ipsum_valid[3]), 64'(1));
        chk("lat_data", 3, 64'(pe_ipsum[3*DW +: DW]), 64'hA5);
        chk("lat_busy", 0, 64'(busy), 64'(1));
        tick();
        pe_ipsum_ready[3] = 1'b1;
        check_all();
        chk("busy_held", 0, 64'(busy), 64'(1));
        tick();
        check_all();
        chk("busy_drop", 0, 64'(busy), 64'(0));
        tick();

        rand_traffic(120, 0);
        drain();

        // depthwise: rows 2 and 5 are zero-fed
        quiet();
        set_mode = 1'b1; depthwise_in = 1'b1;
        step();
        set_mode = 1'b0;
        pe_ipsum_ready = '1; gin_ipsum_valid = '1; gin_ipsum = 32'hDEAD_BEEF;
        check_all();
        chk("dw_valid_r2", 2, 64'(pe_ipsum_valid[23:16]), 64'hFF);
        chk("dw_valid_r5", 5, 64'(pe_ipsum_valid[47:40]), 64'hFF);
        chk("dw_gin_rdy_r2", 2, 64'(gin_ipsum_ready[23:16]), 64'h00);
        chk("dw_gin_rdy_r5", 5, 64'(gin_ipsum_ready[47:40]), 64'h00);
        tick();
        rand_traffic(60, 0);

        // random config churn under traffic
        rand_traffic(200, 6);
        drain();

        // reset with two words buffered
        quiet();
        load_ln(5'b00001);
        pe_opsum_valid[8] = 1'b1; pe_opsum[8*DW +: DW] = 32'h55;
        step();
        pe_opsum[8*DW +: DW] = 32'h66;
        step();
        pe_opsum_valid[8] = 1'b0;
        check_all();
        chk("pre_rst_busy", 0, 64'(busy), 64'(1));
        rst = 1'b0;
        reset_model();
        check_all();
        chk("rst_busy", 0, 64'(busy), 64'(0));
        chk("rst_ipsum_valid", 0, 64'(pe_ipsum_valid), 64'(0));
        tick();
        rst = 1'b1;
        step();
        load_ln(5'b00001);
        pe_opsum_valid[8] = 1'b1; pe_opsum[8*DW +: DW] = 32'h77;
        step();
        pe_opsum_valid[8] = 1'b0;
        check_all();
        chk("post_rst_head", 0, 64'(pe_ipsum[DW-1:0]), 64'h77);
        tick();
        drain();

`ifdef LN_PERF_CNT_EN
        quiet();
        load_ln(5'b00001);
        check_all();
        chk("perf_clear", 0, 64'(ln_fwd_cnt), 64'(0));
        tick();
        pe_ipsum_ready[0] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            pe_opsum_valid[8] = 1'b1; pe_opsum[8*DW +: DW] = 32'(k + 1);
            step();
        end
        pe_opsum_valid[8] = 1'b0;
        step();
        check_all();
        chk("perf_100", 0, 64'(ln_fwd_cnt), 64'd100);
        tick();
        load_ln(5'b00001);
        check_all();
        chk("perf_reload", 0, 64'(ln_fwd_cnt), 64'(0));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
